// File: rtl/powlib_cntrchk.sv
// Sequence checker for counter streams: verifies each valid sample equals the
// previous one plus a fixed step (mod 2^W), reporting err pulse, sticky flag and saturating count.
module powlib_cntrchk #(
  parameter int W    = 8,
  parameter int X    = 1,
  parameter int INIT = 0,
  parameter bit ELD  = 1'b1,
  parameter bit EAS  = 1'b1,
  parameter int ECW  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   in,
  input  logic           vld,
  input  logic           ld,
  input  logic [W-1:0]   nval,
  input  logic           clr,
  output logic [W-1:0]   exp,
  output logic           lock,
  output logic           err,
  output logic           sticky,
  output logic [ECW-1:0] errcnt
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [W-1:0]   STEP      = W'(X);
  localparam logic [W-1:0]   INIT_VAL  = W'(INIT);
  localparam logic [ECW-1:0] CNT_MAX   = {ECW{1'b1}};
  localparam state_t         RST_STATE = EAS ? SYNC : TRACK;

  state_t state_q, state_d;
  logic   ld_en;
  logic   mismatch;

  assign ld_en    = ld && ELD;
  // Only a sample taken while tracking can be wrong; the seed sample is trusted.
  assign mismatch = vld && (state_q == TRACK) && (in != exp);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of the order of always blocks.
  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  // NOTE: the default assignment first keeps this block free of inferred latches.
  always_comb begin
    state_d = state_q;
    if (clr)        state_d = RST_STATE;
    else if (ld_en) state_d = TRACK;
    else if (vld)   state_d = TRACK;
  end

  always_comb begin
    lock = (state_q == TRACK);
  end

  // Datapath: expectation, error pulse, sticky flag and saturating counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      exp    <= INIT_VAL;
      err    <= 1'b0;
      sticky <= 1'b0;
      errcnt <= '0;
    end else if (ld_en) begin
      exp <= nval;
      err <= 1'b0;
    end else if (vld) begin
      // Resync on every sample so a single skip costs exactly one error.
      exp <= in + STEP;
      err <= mismatch;
      if (mismatch) begin
        sticky <= 1'b1;
        if (errcnt != CNT_MAX) errcnt <= errcnt + 1'b1;
      end
    end else begin
      err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_powlib_cntrchk.sv
// Bench for powlib_cntrchk: four parameter variants share one stimulus stream and
// are compared every cycle against a behavioural model, plus directed spot checks.
module tb_powlib_cntrchk;

  localparam int N = 4;
  // Variants: 0 default, 1 down-counter no auto-sync, 2 no load + INIT=0x33, 3 ECW=2
  localparam int P_X    [N] = '{1, -1, 1, 1};
  localparam int P_INIT [N] = '{0, 0, 8'h33, 0};
  localparam bit P_ELD  [N] = '{1'b1, 1'b1, 1'b0, 1'b1};
  localparam bit P_EAS  [N] = '{1'b1, 1'b0, 1'b1, 1'b1};
  localparam int P_ECW  [N] = '{8, 8, 8, 2};

  logic       clk = 1'b0;
  logic       rst, vld, ld, clr;
  logic [7:0] in, nval;

  logic [7:0] exp_o    [N];
  logic       lock_o   [N];
  logic       err_o    [N];
  logic       sticky_o [N];
  logic [7:0] cnt_o    [N];
  logic [1:0] cnt_d;

  int vectors = 0;
  int miscompares = 0;

  int m_exp [N];
  bit m_trk [N];
  bit m_err [N];
  bit m_stk [N];
  int m_cnt [N];

  always #5 clk = ~clk;

  powlib_cntrchk #(.W(8), .X(1), .INIT(0), .ELD(1'b1), .EAS(1'b1), .ECW(8)) u_a (
    .clk(clk), .rst(rst), .in(in), .vld(vld), .ld(ld), .nval(nval), .clr(clr),
    .exp(exp_o[0]), .lock(lock_o[0]), .err(err_o[0]), .sticky(sticky_o[0]), .errcnt(cnt_o[0]));

  powlib_cntrchk #(.W(8), .X(-1), .INIT(0), .ELD(1'b1), .EAS(1'b0), .ECW(8)) u_b (
    .clk(clk), .rst(rst), .in(in), .vld(vld), .ld(ld), .nval(nval), .clr(clr),
    .exp(exp_o[1]), .lock(lock_o[1]), .err(err_o[1]), .sticky(sticky_o[1]), .errcnt(cnt_o[1]));

  powlib_cntrchk #(.W(8), .X(1), .INIT(8'h33), .ELD(1'b0), .EAS(1'b1), .ECW(8)) u_c (
    .clk(clk), .rst(rst), .in(in), .vld(vld), .ld(ld), .nval(nval), .clr(clr),
    .exp(exp_o[2]), .lock(lock_o[2]), .err(err_o[2]), .sticky(sticky_o[2]), .errcnt(cnt_o[2]));

  powlib_cntrchk #(.W(8), .X(1), .INIT(0), .ELD(1'b1), .EAS(1'b1), .ECW(2)) u_d (
    .clk(clk), .rst(rst), .in(in), .vld(vld), .ld(ld), .nval(nval), .clr(clr),
    .exp(exp_o[3]), .lock(lock_o[3]), .err(err_o[3]), .sticky(sticky_o[3]), .errcnt(cnt_d));

  assign cnt_o[3] = {6'b0, cnt_d};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural model of one cycle, written from the rule table.
  task automatic model_step();
    for (int i = 0; i < N; i++) begin
      if (rst || clr) begin
        m_exp[i] = P_INIT[i] % 256;
        m_trk[i] = !P_EAS[i];
        m_err[i] = 1'b0;
        m_stk[i] = 1'b0;
        m_cnt[i] = 0;
      end else if (ld && P_ELD[i]) begin
        m_exp[i] = int'(nval);
        m_trk[i] = 1'b1;
        m_err[i] = 1'b0;
      end else if (vld) begin
        m_err[i] = m_trk[i] && (int'(in) != m_exp[i]);
        if (m_err[i]) begin
          m_stk[i] = 1'b1;
          if (m_cnt[i] < (1 << P_ECW[i]) - 1) m_cnt[i] = m_cnt[i] + 1;
        end
        m_exp[i] = ((int'(in) + P_X[i]) % 256 + 256) % 256;
        m_trk[i] = 1'b1;
      end else begin
        m_err[i] = 1'b0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("exp%0d", i),    32'(exp_o[i]),    32'(m_exp[i]));
      check($sformatf("lock%0d", i),   32'(lock_o[i]),   32'(m_trk[i]));
      check($sformatf("err%0d", i),    32'(err_o[i]),    32'(m_err[i]));
      check($sformatf("sticky%0d", i), 32'(sticky_o[i]), 32'(m_stk[i]));
      check($sformatf("errcnt%0d", i), 32'(cnt_o[i]),    32'(m_cnt[i]));
    end
  endtask

  task automatic drive(input logic r, input logic c, input logic l, input logic [7:0] nv,
                       input logic v, input logic [7:0] d);
    rst = r; clr = c; ld = l; nval = nv; vld = v; in = d;
    cycle();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; ld = 1'b0; vld = 1'b0; in = '0; nval = '0;
    cycle();
    cycle();

    // Reset state
    drive(0, 0, 0, 0, 0, 0);
    check("rst_exp_a", 32'(exp_o[0]), 32'd0);
    check("rst_lock_a", 32'(lock_o[0]), 32'd0);
    check("rst_lock_b", 32'(lock_o[1]), 32'd1);
    check("rst_exp_c", 32'(exp_o[2]), 32'h33);

    // Up-count through wrap: 5..255,0,1
    for (int v = 5; v <= 257; v++) begin
      drive(0, 0, 0, 0, 1, 8'(v));
      if (v == 5) check("seed_lock_a", 32'(lock_o[0]), 32'd1);
    end
    check("wrap_exp_a", 32'(exp_o[0]), 32'd2);
    check("wrap_sticky_a", 32'(sticky_o[0]), 32'd0);

    // Single skip: 10,11,13,14
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 8'd10);
    drive(0, 0, 0, 0, 1, 8'd11);
    drive(0, 0, 0, 0, 1, 8'd13);
    check("skip_err_a", 32'(err_o[0]), 32'd1);
    drive(0, 0, 0, 0, 1, 8'd14);
    check("skip_err_clear_a", 32'(err_o[0]), 32'd0);
    check("skip_cnt_a", 32'(cnt_o[0]), 32'd1);
    check("skip_sticky_a", 32'(sticky_o[0]), 32'd1);

    // Down-counter on variant 1: 0,255,254 then 200
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 8'd0);
    drive(0, 0, 0, 0, 1, 8'd255);
    drive(0, 0, 0, 0, 1, 8'd254);
    check("down_exp_b", 32'(exp_o[1]), 32'd253);
    check("down_sticky_b", 32'(sticky_o[1]), 32'd0);
    drive(0, 0, 0, 0, 1, 8'd200);
    check("down_err_b", 32'(err_o[1]), 32'd1);
    check("down_exp_b2", 32'(exp_o[1]), 32'd199);

    // Load beats same-cycle sample; variant 2 ignores ld
    drive(0, 0, 1, 8'h40, 1, 8'h99);
    check("ld_err_a", 32'(err_o[0]), 32'd0);
    check("ld_exp_a", 32'(exp_o[0]), 32'h40);
    check("noeld_exp_c", 32'(exp_o[2]), 32'h9a);
    drive(0, 0, 0, 0, 1, 8'h40);
    check("ld_next_exp_a", 32'(exp_o[0]), 32'h41);
    check("ld_next_err_a", 32'(err_o[0]), 32'd0);

    // Three errors, then clr with a mismatching sample
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 8'd0);
    drive(0, 0, 0, 0, 1, 8'd5);
    drive(0, 0, 0, 0, 1, 8'd9);
    drive(0, 0, 0, 0, 1, 8'd13);
    check("pre_clr_cnt_a", 32'(cnt_o[0]), 32'd3);
    drive(0, 1, 0, 0, 1, 8'd99);
    check("clr_err_a", 32'(err_o[0]), 32'd0);
    check("clr_cnt_a", 32'(cnt_o[0]), 32'd0);
    check("clr_sticky_a", 32'(sticky_o[0]), 32'd0);
    check("clr_exp_a", 32'(exp_o[0]), 32'd0);
    check("clr_lock_a", 32'(lock_o[0]), 32'd0);

    // Saturation on the 2-bit counter variant
    drive(0, 0, 0, 0, 1, 8'd0);
    for (int k = 1; k <= 6; k++) begin
      drive(0, 0, 0, 0, 1, 8'(k * 10));
      check($sformatf("sat_err_d_%0d", k), 32'(err_o[3]), 32'd1);
      check($sformatf("sat_cnt_d_%0d", k), 32'(cnt_o[3]), (k < 3) ? 32'(k) : 32'd3);
    end
    drive(1, 0, 0, 0, 1, 8'd77);
    check("rst_err_d", 32'(err_o[3]), 32'd0);
    check("rst_cnt_d", 32'(cnt_o[3]), 32'd0);
    check("rst_sticky_d", 32'(sticky_o[3]), 32'd0);
    check("rst_lock_d", 32'(lock_o[3]), 32'd0);
    check("rst_exp_d", 32'(exp_o[3]), 32'd0);

    // Randomised traffic, mostly in-sequence for variant 0
    for (int n = 0; n < 400; n++) begin
      logic [7:0] d;
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(m_exp[0]);
      drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
            ($urandom_range(0, 15) == 0), 8'($urandom),
            ($urandom_range(0, 3) != 0), d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/powlib_cntrchk.md
# powlib_cntrchk

Sequence checker for counter streams: it consumes a sampled count value plus valid and verifies each sample equals the previous one plus a fixed step, modulo 2^W. It is the receiving end of the powlib_cntr output. It sits on the consuming side of any counter-driven datapath, such as sequence numbers, address generators or pointer streams, and reports discontinuities with a pulse, a sticky flag and a saturating error count. It mirrors the counter's init, load and clear controls so both ends can be kept in lockstep.

## Interface
- W, 8, data width of checked values
- X, 1, step per valid sample, W-bit two's complement (X = -1 checks a down-counter)
- INIT, 0, expected value after reset/clear
- ELD, 1, enable load feature (ld/nval); when 0, ld is ignored
- EAS, 1, enable auto-sync: first valid sample after reset/clear is accepted unchecked and seeds the expectation
- ECW, 8, error counter width

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- in  in  W  sampled count value
- vld  in  1  in is valid this cycle
- ld  in  1  load expected value from nval (ELD=1 only)
- nval  in  W  value loaded on ld
- clr  in  1  synchronous clear of expectation and error state
- exp  out  W  value the next valid sample must equal
- lock  out  1  checker is in TRACK state
- err  out  1  one-cycle pulse, previous-cycle sample mismatched
- sticky  out  1  set on any mismatch, held until rst/clr
- errcnt  out  ECW  mismatch count, saturates at 2^ECW-1

## Operation
- States: SYNC (awaiting seed sample) and TRACK (checking). Reset/clear enters SYNC if EAS=1, otherwise TRACK.
- SYNC, vld=1: exp <= in + X; go to TRACK. No check, no err.
- TRACK, vld=1, in == exp: exp <= in + X; err <= 0.
- TRACK, vld=1, in != exp: err <= 1; sticky <= 1; errcnt <= errcnt+1 unless saturated; exp <= in + X (resync, so one skip yields exactly one error); stay in TRACK.
- vld=0: exp, state and counters hold; err <= 0.
- Arithmetic: in + X truncated to W bits. Wrap is legal: X=1 gives 2^W-1 -> 0; X=-1 gives 0 -> 2^W-1.
- Priority per cycle: rst > clr > ld > vld.
  - clr: exp <= INIT; errcnt, sticky, err <= 0; state per EAS. Same-cycle ld/vld ignored.
  - ld (ELD=1): exp <= nval; state <= TRACK; err <= 0; errcnt/sticky unchanged. Same-cycle vld sample is discarded, not checked.
  - ELD=0: ld and nval have no effect.

## Timing
- Reset values: exp=INIT, lock = (EAS ? 0 : 1), err=0, sticky=0, errcnt=0.
- All outputs registered; no combinational input-to-output path.
- Check latency is one cycle. A sample at edge N produces err, sticky and errcnt at edge N+1, together with the updated exp.
- Back-to-back vld every cycle is supported with no bubbles. Each cycle's err reflects only the sample from the previous cycle.
- lock rises the cycle after the seeding sample (EAS=1) or after ld. It falls the cycle after clr (EAS=1) or rst.
- Reset or clear during a mismatch cycle suppresses the pending err pulse.
- errcnt saturated: further mismatches still pulse err, and the count holds at max.

## Test plan
- W=8, X=1, EAS=1: drive vld with in = 5,6,...,255,0,1 -> first sample seeds; lock=1 after first edge; err never asserts; exp=2 at end.
- X=1 stream 10,11,13,14 -> single err pulse the cycle after 13; errcnt=1; sticky=1; 14 accepted with no further error.
- X=-1 (dut with -1 step), EAS=0, INIT=0: in = 0,255,254 -> no err; exp=253. Then in=200 -> err pulse; exp=199.
- ld with nval=0x40 and vld=1, in=0x99 in the same cycle -> no err; exp=0x40. Next in=0x40 -> no err; exp=0x41. ELD=0 build: ld has no effect.
- After errors (errcnt=3, sticky=1), assert clr together with a mismatching vld -> err stays 0; errcnt=0; sticky=0; exp=INIT; lock=0 (EAS=1).
- ECW=2, six consecutive mismatching samples -> six err pulses; errcnt sequence 1,2,3,3,3,3. Then rst -> all outputs return to reset values next edge.
